pwm_duty_ctrl: RTL and testbench

- Runtime-programmable duty-cycle clock/PWM generator with a config handshake; replaces fixed-parameter divider instances where period/high time must change in-system.
- Holds an active config (period P, high H) plus a one-deep pending shadow.
- Applies updates only at period boundaries, so the output never glitches or produces a truncated pulse.
- Sits between a register/CSR master (config side) and downstream logic consuming pwm_out and period_start.

---
 rtl/pwm_duty_ctrl_if.sv | 38 +++
 rtl/pwm_duty_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ctrl_if.sv
// Config handshake, run control and waveform outputs of pwm_duty_ctrl.
// Burst signals exist only when PWM_BURST_EN is defined.
interface pwm_duty_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_err;
    logic             cfg_applied;
    logic             pwm_out;
    logic             period_start;
    logic             active;
`ifdef PWM_BURST_EN
    logic [15:0]      burst_len;
    logic             burst_done;

    modport master (
        output enable, cfg_valid, cfg_period, cfg_high, burst_len,
        input  cfg_ready, cfg_err, cfg_applied, pwm_out, period_start, active, burst_done
    );
    modport slave (
        input  enable, cfg_valid, cfg_period, cfg_high, burst_len,
        output cfg_ready, cfg_err, cfg_applied, pwm_out, period_start, active, burst_done
    );
`else
    modport master (
        output enable, cfg_valid, cfg_period, cfg_high,
        input  cfg_ready, cfg_err, cfg_applied, pwm_out, period_start, active
    );
    modport slave (
        input  enable, cfg_valid, cfg_period, cfg_high,
        output cfg_ready, cfg_err, cfg_applied, pwm_out, period_start, active
    );
`endif
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Runtime-programmable PWM: active period/high plus one-deep pending shadow, applied only at period
// boundaries (or the cycle after acceptance when idle). Outputs registered; optional PWM_BURST_EN bursts.
module pwm_duty_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_PERIOD = 10,
    parameter int unsigned DEF_HIGH   = 6
) (
    input logic            clk,
    input logic            reset,
    pwm_duty_ctrl_if.slave pwm_if
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] pend_per_q, pend_per_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pwm_q, pwm_d;
    logic             pstart_q, pstart_d;
    logic             active_q, active_d;
    logic             err_q, err_d;
    logic             applied_q, applied_d;

    logic             boundary, apply, accept, legal;
    logic             burst_last, start_ok;
    logic [CNT_W-1:0] high_eff, pos_inc;

`ifdef PWM_BURST_EN
    logic [15:0]      left_q, left_d;
    logic             lock_q, lock_d;
    logic             done_q, done_d;

    // lock_q blocks a restart until enable has been seen low after a burst ends
    assign burst_last = (left_q == 16'd1);
    assign start_ok   = !lock_q;
    assign pwm_if.burst_done = done_q;
`else
    assign burst_last = 1'b0;
    assign start_ok   = 1'b1;
`endif

    always_comb begin
        boundary = (state_q == RUN) && (pos_q == per_q - ONE);
        apply    = pend_vld_q && ((state_q == IDLE) || boundary);
        accept   = pwm_if.cfg_valid && !pend_vld_q;
        legal    = (pwm_if.cfg_period != '0) && (pwm_if.cfg_high <= pwm_if.cfg_period);
        high_eff = apply ? pend_high_q : high_q;
        pos_inc  = pos_q + ONE;
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        per_d       = per_q;
        high_d      = high_q;
        pend_vld_d  = pend_vld_q;
        pend_per_d  = pend_per_q;
        pend_high_d = pend_high_q;
        pwm_d       = pwm_q;
        pstart_d    = 1'b0;
        active_d    = active_q;
        err_d       = 1'b0;
        applied_d   = 1'b0;
`ifdef PWM_BURST_EN
        left_d      = left_q;
        lock_d      = lock_q;
        done_d      = 1'b0;
`endif

        // apply needs a pending entry and accept needs none, so they never coincide
        if (apply) begin
            per_d      = pend_per_q;
            high_d     = pend_high_q;
            pend_vld_d = 1'b0;
            applied_d  = 1'b1;
        end

        if (accept) begin
            if (legal) begin
                pend_vld_d  = 1'b1;
                pend_per_d  = pwm_if.cfg_period;
                pend_high_d = pwm_if.cfg_high;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                pos_d    = '0;
                pwm_d    = 1'b0;
                active_d = 1'b0;
`ifdef PWM_BURST_EN
                if (!pwm_if.enable) lock_d = 1'b0;
`endif
                if (pwm_if.enable && start_ok) begin
                    state_d  = RUN;
                    pwm_d    = (high_eff != '0);
                    pstart_d = 1'b1;
                    active_d = 1'b1;
`ifdef PWM_BURST_EN
                    left_d   = pwm_if.burst_len;
`endif
                end
            end
            RUN: begin
                if (boundary) begin
                    pos_d = '0;
                    if (!pwm_if.enable || burst_last) begin
                        state_d  = IDLE;
                        pwm_d    = 1'b0;
                        active_d = 1'b0;
                    end else begin
                        pwm_d    = (high_eff != '0);
                        pstart_d = 1'b1;
                    end
`ifdef PWM_BURST_EN
                    if (burst_last) begin
                        done_d = 1'b1;
                        lock_d = 1'b1;
                        left_d = '0;
                    end else if (left_q > 16'd1) begin
                        left_d = left_q - 16'd1;
                    end
`endif
                end else begin
                    pos_d = pos_inc;
                    pwm_d = (pos_inc < high_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            per_q       <= DEF_P;
            high_q      <= DEF_H;
            pend_vld_q  <= 1'b0;
            pend_per_q  <= '0;
            pend_high_q <= '0;
            pwm_q       <= 1'b0;
            pstart_q    <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            applied_q   <= 1'b0;
`ifdef PWM_BURST_EN
            left_q      <= '0;
            lock_q      <= 1'b0;
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            per_q       <= per_d;
            high_q      <= high_d;
            pend_vld_q  <= pend_vld_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
            active_q    <= active_d;
            err_q       <= err_d;
            applied_q   <= applied_d;
`ifdef PWM_BURST_EN
            left_q      <= left_d;
            lock_q      <= lock_d;
            done_q      <= done_d;
`endif
        end
    end

    assign pwm_if.cfg_ready    = !pend_vld_q;
    assign pwm_if.cfg_err      = err_q;
    assign pwm_if.cfg_applied  = applied_q;
    assign pwm_if.pwm_out      = pwm_q;
    assign pwm_if.period_start = pstart_q;
    assign pwm_if.active       = active_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: directed scenarios with literal waveform expectations, then randomized
// traffic checked every cycle against a queue-based behavioural model.
module tb_pwm_duty_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pwm_duty_ctrl_if #(.CNT_W(8)) b();

    pwm_duty_ctrl #(.CNT_W(8), .DEF_PERIOD(10), .DEF_HIGH(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_if (b)
    );

    typedef struct packed { logic [7:0] p; logic [7:0] h; } cfg_t;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: running flag, position within period, active config, pending queue
    bit   m_run;
    int   m_pos, m_P, m_H;
    cfg_t m_pend[$];
    bit   e_err, e_applied, e_done;
    int   m_left;
    bit   m_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_P = 10; m_H = 6;
        m_pend.delete();
        e_err = 0; e_applied = 0; e_done = 0;
        m_left = 0; m_lock = 0;
    endtask

    task automatic model_edge();
        bit   boundary, apply, acc, legal;
        cfg_t c;
        boundary  = m_run && (m_pos == m_P - 1);
        apply     = (m_pend.size() != 0) && (!m_run || boundary);
        acc       = b.cfg_valid && (m_pend.size() == 0);
        legal     = (b.cfg_period != 0) && (b.cfg_high <= b.cfg_period);
        e_err     = acc && !legal;
        e_applied = apply;
        e_done    = 0;
        if (apply) begin
            c = m_pend.pop_front();
            m_P = c.p; m_H = c.h;
        end
        if (acc && legal) m_pend.push_back({b.cfg_period, b.cfg_high});
        if (!m_run) begin
            if (!b.enable) m_lock = 0;
            else if (!m_lock) begin
                m_run = 1; m_pos = 0;
`ifdef PWM_BURST_EN
                m_left = b.burst_len;
`endif
            end
        end else if (boundary) begin
            m_pos = 0;
            if (m_left == 1) begin
                m_run = 0; e_done = 1; m_lock = 1; m_left = 0;
            end else begin
                if (m_left > 1) m_left--;
                if (!b.enable) m_run = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic compare_all();
        chk("pwm_out",      b.pwm_out,      (m_run && m_pos < m_H));
        chk("period_start", b.period_start, (m_run && m_pos == 0));
        chk("active",       b.active,       m_run);
        chk("cfg_ready",    b.cfg_ready,    (m_pend.size() == 0));
        chk("cfg_err",      b.cfg_err,      e_err);
        chk("cfg_applied",  b.cfg_applied,  e_applied);
`ifdef PWM_BURST_EN
        chk("burst_done",   b.burst_done,   e_done);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic offer(input int p, input int h);
        b.cfg_valid = 1'b1; b.cfg_period = 8'(p); b.cfg_high = 8'(h);
        step();
        b.cfg_valid = 1'b0;
    endtask

    task automatic wait_applied(input string name, input int maxc);
        int n = 0;
        do begin
            step();
            n++;
        end while (b.cfg_applied !== 1'b1 && n < maxc);
        chk(name, b.cfg_applied, 1'b1);
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    logic [9:0] pat, psp;
    int         cnt, cnt2;

    initial begin
        model_reset();
        b.enable = 1'b0; b.cfg_valid = 1'b0; b.cfg_period = '0; b.cfg_high = '0;
`ifdef PWM_BURST_EN
        b.burst_len = '0;
`endif
        #2;
        chk("rst_pwm",    b.pwm_out,      1'b0);
        chk("rst_active", b.active,       1'b0);
        chk("rst_ready",  b.cfg_ready,    1'b1);
        chk("rst_pstart", b.period_start, 1'b0);
        step(); step();
        reset = 1'b0;

        // defaults: 1111110000, period_start on position 0, active one cycle after enable
        b.enable = 1'b1;
        pat = '0; psp = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) chk("active_first_cycle", b.active, 1'b1);
            pat = {pat[8:0], b.pwm_out};
            psp = {psp[8:0], b.period_start};
        end
        chk("default_pattern", pat, 10'b1111110000);
        chk("default_pstart",  psp, 10'b1000000000);

        // mid-period update to P=4,H=1 takes effect only at the next position 0
        step(); step();
        offer(4, 1);
        chk("ready_drops", b.cfg_ready, 1'b0);
        for (int i = 0; i < 7; i++) step();
        step();
        chk("applied_at_pos0", b.cfg_applied, 1'b1);
        chk("ready_back",      b.cfg_ready,   1'b1);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step();
            pat = {pat[8:0], b.pwm_out};
        end
        chk("p4h1_pattern", pat[7:0], 8'b10001000);

        // illegal configs are refused with a one-cycle error
        offer(5, 6);
        chk("err_h_gt_p",  b.cfg_err,   1'b1);
        chk("err_ready_a", b.cfg_ready, 1'b1);
        step();
        chk("err_one_cycle", b.cfg_err, 1'b0);
        offer(0, 0);
        chk("err_p_zero",  b.cfg_err,   1'b1);
        chk("err_ready_b", b.cfg_ready, 1'b1);

        // graceful disable at position 3 of a 10-cycle period
        offer(10, 6);
        wait_applied("apply_p10", 12);
        step(); step(); step();
        b.enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b.active === 1'b1) cnt++;
        end
        chk("disable_tail_len", cnt, 6);
        chk("idle_pwm", b.pwm_out, 1'b0);

        // H=0,P=3 applied while idle, then constant 0
        offer(3, 0);
        step();
        chk("idle_apply", b.cfg_applied, 1'b1);
        b.enable = 1'b1;
        pat = '0; psp = '0;
        for (int i = 0; i < 9; i++) begin
            step();
            pat = {pat[8:0], b.pwm_out};
            psp = {psp[8:0], b.period_start};
        end
        chk("h0_pattern", pat[8:0], 9'b000000000);
        chk("h0_pstart",  psp[8:0], 9'b100100100);

        // H=3,P=3: constant 1, period_start still every 3 cycles
        offer(3, 3);
        wait_applied("apply_h3p3", 6);
        pat = '0; psp = '0;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) step();
            pat = {pat[8:0], b.pwm_out};
            psp = {psp[8:0], b.period_start};
        end
        chk("hp_pattern", pat[8:0], 9'b111111111);
        chk("hp_pstart",  psp[8:0], 9'b100100100);

        // reset at position 7 with an update pending discards the update
        offer(10, 6);
        wait_applied("apply_p10b", 6);
        offer(4, 2);
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_pwm",    b.pwm_out,      1'b0);
        chk("mid_rst_active", b.active,       1'b0);
        chk("mid_rst_pstart", b.period_start, 1'b0);
        chk("mid_rst_ready",  b.cfg_ready,    1'b1);
        model_reset();
        #1;
        reset = 1'b0;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            pat = {pat[8:0], b.pwm_out};
        end
        chk("post_rst_pattern", pat, 10'b1111110000);

`ifdef PWM_BURST_EN
        // three-period burst ends in IDLE even though enable stays high
        async_reset_pulse();
        b.burst_len = 16'd3;
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (b.period_start === 1'b1) cnt++;
            if (b.burst_done === 1'b1) cnt2++;
        end
        chk("burst_periods", cnt,      3);
        chk("burst_done",    cnt2,     1);
        chk("burst_idle",    b.active, 1'b0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) b.enable = ~b.enable;
            b.cfg_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) b.cfg_period = 8'($urandom_range(200, 255));
            else b.cfg_period = 8'($urandom_range(0, 12));
            b.cfg_high = 8'($urandom_range(0, int'(b.cfg_period) + 1));
`ifdef PWM_BURST_EN
            b.burst_len = 16'($urandom_range(0, 3));
`endif
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
